regfile_mp: RTL and testbench

- Parametrised multi-port integer register file; successor to the single-write, two-read file, for the dual-issue core.
- Provides NUM_READ combinational read ports and NUM_WRITE synchronous write ports.
- Adds a per-register pending scoreboard: issue sets a bit, writeback clears it.
- Sits between decode/issue (reads, pending set) and writeback (writes, pending clear).

---
 rtl/regfile_mp_pkg.sv | 20 ++
 rtl/regfile_mp_wsel.sv | 36 +++
 rtl/regfile_mp.sv | 125 ++++++++++++
 tb/tb_regfile_mp.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared types and default sizes for the multi-port integer register file.
package regfile_mp_pkg;

    // Default architectural register count and word width.
    localparam int CREG_NUM = 32;
    localparam int CREG_AW  = $clog2(CREG_NUM);
    localparam int WORD_W   = 32;

    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [CREG_AW-1:0] creg_addr_t;

    // Extract write/read port p's address from a port-packed address bus.
    function automatic creg_addr_t port_addr(
        input logic [8*CREG_AW-1:0] bus,
        input int unsigned          p
    );
        return bus[p*CREG_AW +: CREG_AW];
    endfunction

endpackage

// File: rtl/regfile_mp_wsel.sv
// Per-register write-port priority select for regfile_mp.
// For every register r != 0, flags whether any valid write port targets it
// and returns the data of the highest-index matching port. Register 0 never
// hits. Shared by the register write path and the optional bypass path.
module regfile_mp_wsel
    import regfile_mp_pkg::*;
#(
    parameter int NUM_REGS   = CREG_NUM,
    parameter int DATA_WIDTH = WORD_W,
    parameter int NUM_WRITE  = 2,
    parameter int AW         = $clog2(NUM_REGS)
) (
    input  logic [NUM_WRITE-1:0]            wvalid,
    input  logic [NUM_WRITE*AW-1:0]         waddr,
    input  logic [NUM_WRITE*DATA_WIDTH-1:0] wdata,
    output logic                            hit [NUM_REGS],
    output logic [DATA_WIDTH-1:0]           sel [NUM_REGS]
);

    // Scan ports low to high so a later (higher-index) match overrides.
    always_comb begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            hit[r] = 1'b0;
            sel[r] = '0;
        end
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            for (int unsigned i = 0; i < NUM_WRITE; i++) begin
                if (wvalid[i] && (waddr[i*AW +: AW] == AW'(r))) begin
                    hit[r] = 1'b1;
                    sel[r] = wdata[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with per-register pending scoreboard.
// NUM_READ combinational read ports, NUM_WRITE synchronous write ports,
// register 0 hardwired to zero. Issue sets a pending bit, writeback clears
// it, flush clears all pending bits.
// Optional build macro REGFILE_MP_BYPASS_EN: reads forward same-cycle write
// data (highest-index matching port) and report the register as not pending.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int NUM_REGS   = CREG_NUM,
    parameter int DATA_WIDTH = WORD_W,
    parameter int NUM_READ   = 4,
    parameter int NUM_WRITE  = 2,
    parameter int AW         = $clog2(NUM_REGS)
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic [NUM_READ*AW-1:0]          ra,
    output logic [NUM_READ*DATA_WIDTH-1:0]  rdata,
    output logic [NUM_READ-1:0]             rpending,
    input  logic [NUM_WRITE-1:0]            wvalid,
    input  logic [NUM_WRITE*AW-1:0]         waddr,
    input  logic [NUM_WRITE*DATA_WIDTH-1:0] wdata,
    output logic [NUM_WRITE*DATA_WIDTH-1:0] worig,
    input  logic [NUM_WRITE-1:0]            iss_valid,
    input  logic [NUM_WRITE*AW-1:0]         iss_id,
    input  logic                            flush
);

    logic [DATA_WIDTH-1:0] regs    [NUM_REGS];
    logic                  pending [NUM_REGS];

    logic                  whit    [NUM_REGS];
    logic [DATA_WIDTH-1:0] wsel    [NUM_REGS];
    logic                  iss_hit [NUM_REGS];

    regfile_mp_wsel #(
        .NUM_REGS   (NUM_REGS),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_WRITE  (NUM_WRITE),
        .AW         (AW)
    ) u_wsel (
        .wvalid (wvalid),
        .waddr  (waddr),
        .wdata  (wdata),
        .hit    (whit),
        .sel    (wsel)
    );

    // Per-register issue match; duplicates across slots collapse to one set.
    always_comb begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            iss_hit[r] = 1'b0;
        end
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            for (int unsigned j = 0; j < NUM_WRITE; j++) begin
                if (iss_valid[j] && (iss_id[j*AW +: AW] == AW'(r))) begin
                    iss_hit[r] = 1'b1;
                end
            end
        end
    end

    // Register storage; entry 0 is only ever reset, so it reads as zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int unsigned r = 1; r < NUM_REGS; r++) begin
                if (whit[r]) begin
                    regs[r] <= wsel[r];
                end
            end
        end
    end

    // Pending scoreboard: flush > new producer > writeback clear > hold.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                pending[r] <= 1'b0;
            end
        end else begin
            for (int unsigned r = 1; r < NUM_REGS; r++) begin
                if (flush) begin
                    pending[r] <= 1'b0;
                end else if (iss_hit[r]) begin
                    pending[r] <= 1'b1;
                end else if (whit[r]) begin
                    pending[r] <= 1'b0;
                end
            end
        end
    end

    // Combinational read ports, optionally forwarding same-cycle writes.
    always_comb begin
        rdata    = '0;
        rpending = '0;
        for (int unsigned k = 0; k < NUM_READ; k++) begin
            rdata[k*DATA_WIDTH +: DATA_WIDTH] = regs[ra[k*AW +: AW]];
            rpending[k]                       = pending[ra[k*AW +: AW]];
`ifdef REGFILE_MP_BYPASS_EN
            // Gated by resetn so outputs stay zero while reset is held.
            if (resetn && whit[ra[k*AW +: AW]]) begin
                rdata[k*DATA_WIDTH +: DATA_WIDTH] = wsel[ra[k*AW +: AW]];
                rpending[k]                       = 1'b0;
            end
`else
            rdata = rdata;
`endif
        end
    end

    // Pre-edge value of each write port's target; register 0 reads zero.
    always_comb begin
        worig = '0;
        for (int unsigned i = 0; i < NUM_WRITE; i++) begin
            worig[i*DATA_WIDTH +: DATA_WIDTH] = regs[waddr[i*AW +: AW]];
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (default parameters).
// Expectations for the same-cycle read/write case follow REGFILE_MP_BYPASS_EN.
module tb_regfile_mp;

    localparam int NR = 32;
    localparam int DW = 32;
    localparam int RP = 4;
    localparam int WP = 2;
    localparam int AW = 5;

    logic              clk;
    logic              resetn;
    logic [RP*AW-1:0]  ra;
    logic [RP*DW-1:0]  rdata;
    logic [RP-1:0]     rpending;
    logic [WP-1:0]     wvalid;
    logic [WP*AW-1:0]  waddr;
    logic [WP*DW-1:0]  wdata;
    logic [WP*DW-1:0]  worig;
    logic [WP-1:0]     iss_valid;
    logic [WP*AW-1:0]  iss_id;
    logic              flush;

    int n_total = 0;
    int n_bad   = 0;

    regfile_mp #(
        .NUM_REGS   (NR),
        .DATA_WIDTH (DW),
        .NUM_READ   (RP),
        .NUM_WRITE  (WP)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .ra        (ra),
        .rdata     (rdata),
        .rpending  (rpending),
        .wvalid    (wvalid),
        .waddr     (waddr),
        .wdata     (wdata),
        .worig     (worig),
        .iss_valid (iss_valid),
        .iss_id    (iss_id),
        .flush     (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        wvalid    = '0;
        iss_valid = '0;
        flush     = 1'b0;
    endtask

    task automatic wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wvalid[p]         = 1'b1;
        waddr[p*AW +: AW] = a;
        wdata[p*DW +: DW] = d;
    endtask

    task automatic iss(input int p, input logic [AW-1:0] a);
        iss_valid[p]       = 1'b1;
        iss_id[p*AW +: AW] = a;
    endtask

    task automatic rd(input int p, input logic [AW-1:0] a);
        ra[p*AW +: AW] = a;
    endtask

    function automatic logic [DW-1:0] rdat(input int p);
        return rdata[p*DW +: DW];
    endfunction

    initial begin
        resetn = 1'b0;
        ra     = '0;
        waddr  = '0;
        wdata  = '0;
        iss_id = '0;
        idle();

        // Reset held: every register reads zero and not pending.
        for (int r = 0; r < NR; r++) begin
            @(negedge clk);
            rd(0, AW'(r));
            #1;
            chk($sformatf("rst_data_r%0d", r), 64'(rdat(0)), 64'h0);
            chk($sformatf("rst_pend_r%0d", r), 64'(rpending[0]), 64'h0);
        end
        @(negedge clk);
        resetn = 1'b1;
        rd(0, 5'd0);
        rd(1, 5'd31);
        #1;
        chk("post_rst_r0", 64'(rdat(0)), 64'h0);
        chk("post_rst_r31", 64'(rdat(1)), 64'h0);

        // Dual write; worig shows pre-write values.
        @(negedge clk);
        idle();
        wr(0, 5'd3, 32'h3333_3333);
        wr(1, 5'd5, 32'hAAAA_0005);
        #1;
        chk("worig_dual", 64'(worig), 64'h0);
        @(negedge clk);
        idle();
        rd(0, 5'd3);
        rd(1, 5'd5);
        #1;
        chk("dual_r3", 64'(rdat(0)), 64'h3333_3333);
        chk("dual_r5", 64'(rdat(1)), 64'hAAAA_0005);

        // Conflict on reg 7: port 1 wins.
        @(negedge clk);
        idle();
        wr(0, 5'd7, 32'h1);
        wr(1, 5'd7, 32'h2);
        @(negedge clk);
        idle();
        rd(0, 5'd7);
        #1;
        chk("conflict_r7", 64'(rdat(0)), 64'h2);

        // Write to reg 0 discarded; worig of reg 5 is old value.
        @(negedge clk);
        idle();
        wr(0, 5'd0, 32'hFFFF_FFFF);
        wr(1, 5'd5, 32'h55);
        #1;
        chk("worig_r0", 64'(worig[DW-1:0]), 64'h0);
        chk("worig_r5", 64'(worig[2*DW-1:DW]), 64'hAAAA_0005);
        @(negedge clk);
        idle();
        rd(0, 5'd0);
        rd(1, 5'd5);
        #1;
        chk("wr_r0_dropped", 64'(rdat(0)), 64'h0);
        chk("rewrite_r5", 64'(rdat(1)), 64'h55);

        // Scoreboard: issue reg 9 (and ignored id 0).
        @(negedge clk);
        idle();
        iss(0, 5'd9);
        iss(1, 5'd0);
        rd(0, 5'd9);
        rd(1, 5'd0);
        #1;
        chk("pend9_before_edge", 64'(rpending[0]), 64'h0);
        @(negedge clk);
        idle();
        #1;
        chk("pend9_set", 64'(rpending[0]), 64'h1);
        chk("pend0_never", 64'(rpending[1]), 64'h0);

        // Writeback and new issue in same cycle: stays pending.
        @(negedge clk);
        idle();
        wr(0, 5'd9, 32'h99);
        iss(1, 5'd9);
        @(negedge clk);
        idle();
        #1;
        chk("pend9_wb_iss", 64'(rpending[0]), 64'h1);
        chk("data9_wb_iss", 64'(rdat(0)), 64'h99);

        // Writeback only clears.
        @(negedge clk);
        idle();
        wr(1, 5'd9, 32'h9A);
        @(negedge clk);
        idle();
        #1;
        chk("pend9_wb_only", 64'(rpending[0]), 64'h0);
        chk("data9_wb_only", 64'(rdat(0)), 64'h9A);

        // Set 4 and 9, then flush (beats issue; write still commits).
        @(negedge clk);
        idle();
        iss(0, 5'd4);
        iss(1, 5'd9);
        @(negedge clk);
        idle();
        rd(1, 5'd4);
        #1;
        chk("pend_4_9_set", 64'(rpending[1:0]), 64'h3);
        @(negedge clk);
        idle();
        flush = 1'b1;
        iss(0, 5'd9);
        wr(1, 5'd20, 32'h2020);
        @(negedge clk);
        idle();
        rd(2, 5'd20);
        #1;
        chk("flush_pend", 64'(rpending), 64'h0);
        chk("flush_data9", 64'(rdat(0)), 64'h9A);
        chk("flush_data4", 64'(rdat(1)), 64'h0);
        chk("flush_wr20", 64'(rdat(2)), 64'h2020);

        // Same-cycle read/write of reg 12 while pending.
        @(negedge clk);
        idle();
        wr(0, 5'd12, 32'h10);
        iss(1, 5'd12);
        @(negedge clk);
        idle();
        rd(0, 5'd12);
        #1;
        chk("r12_old", 64'(rdat(0)), 64'h10);
        chk("r12_pend", 64'(rpending[0]), 64'h1);
        @(negedge clk);
        idle();
        wr(1, 5'd12, 32'h20);
        #1;
`ifdef REGFILE_MP_BYPASS_EN
        chk("r12_same_data", 64'(rdat(0)), 64'h20);
        chk("r12_same_pend", 64'(rpending[0]), 64'h0);
`else
        chk("r12_same_data", 64'(rdat(0)), 64'h10);
        chk("r12_same_pend", 64'(rpending[0]), 64'h1);
`endif
        chk("r12_worig", 64'(worig[2*DW-1:DW]), 64'h10);
        @(negedge clk);
        idle();
        #1;
        chk("r12_new", 64'(rdat(0)), 64'h20);
        chk("r12_cleared", 64'(rpending[0]), 64'h0);

        // Async reset between edges with a write in flight.
        @(negedge clk);
        idle();
        wr(0, 5'd12, 32'h30);
        rd(1, 5'd3);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_r12", 64'(rdat(0)), 64'h0);
        chk("async_r3", 64'(rdat(1)), 64'h0);
        chk("async_worig", 64'(worig[DW-1:0]), 64'h0);
        @(negedge clk);
        idle();
        resetn = 1'b1;
        #1;
        chk("after_async_r12", 64'(rdat(0)), 64'h0);
        chk("after_async_r3", 64'(rdat(1)), 64'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
